sprite_draw_engine: RTL
=======================

// Module: sprite_draw_engine
// PURPOSE
//   Executes the DRAW_LINK phase of the game FSM: while draw_link is high, scans one
//   SPRITE_W x SPRITE_H sprite frame from a synchronous sprite ROM and plots its
//   non-transparent pixels into the VGA adapter at the latched player position.
//   Returns draw_link_done so the FSM can advance to DRAW_ENEMIES.
//   Sits between the control FSM and the VGA adapter write port.
// PARAMETERS
//   SPRITE_W     16   sprite width in pixels (power of 2)
//   SPRITE_H     16   sprite height in pixels (power of 2)
//   SCREEN_W     160  visible width; columns >= SCREEN_W are clipped
//   SCREEN_H     120  visible height; rows >= SCREEN_H are clipped
//   COLOR_W      3    colour bits per pixel
//   TRANSPARENT  3'b000  ROM colour value that is never plotted
// PORTS
//   clock       in   1   system clock (CLOCK_50)
//   reset       in   1   synchronous, active-high
//   start       in   1   level request, driven by FSM draw_link
//   x_pos       in   8   sprite top-left column; latched at start
//   y_pos       in   7   sprite top-left row; latched at start
//   facing      in   2   frame select (0 up, 1 down, 2 left, 3 right); latched at start
//   rom_addr    out  10  {facing, row[3:0], col[3:0]}; ROM data is valid 1 cycle later
//   rom_data    in   COLOR_W  pixel colour for the previous cycle's rom_addr
//   vga_x       out  8   plot column (registered)
//   vga_y       out  7   plot row (registered)
//   vga_colour  out  COLOR_W  plot colour (registered)
//   vga_plot    out  1   write enable to the VGA adapter (registered)
//   done        out  1   drives FSM draw_link_done (registered)
// BEHAVIOUR
//   Reset: state IDLE; counters, latched pos/facing, vga_x/vga_y/vga_colour, vga_plot and done all 0.
//   States: IDLE, SCAN, FLUSH, DONE.
//   - IDLE: on a clock edge that samples start=1, latch x_pos/y_pos/facing, clear row/col
//     counters, enter SCAN. Input changes after latching are ignored.
//   - SCAN: rom_addr = {facing_l,row,col}; col increments every cycle, wraps at SPRITE_W-1
//     and increments row. After addressing row=SPRITE_H-1, col=SPRITE_W-1, enter FLUSH.
//     SCAN lasts exactly SPRITE_W*SPRITE_H cycles (256).
//   - Pipeline: stage 1 registers (valid, row, col) alongside the ROM read. Stage 2 registers
//     vga_x = x_l+col, vga_y = y_l+row, vga_colour = rom_data, and
//     vga_plot = valid & (rom_data != TRANSPARENT) & on-screen. The address-to-vga_plot
//     latency is 2 cycles.
//   - Arithmetic: sums are formed at 9/8 bits. A pixel is on-screen only if
//     x_l+col < SCREEN_W and y_l+row < SCREEN_H. Pixels are clipped and never wrapped.
//   - FLUSH: 2 cycles that drain the pipeline, then DONE.
//   - DONE: done=1 and vga_plot=0. DONE stays in place while start=1, so the engine does not
//     retrigger. When start=0 is sampled, go to IDLE and drop done on the same edge.
//   - Abort: if start=0 is sampled in SCAN or FLUSH, go to IDLE and clear both pipeline valid
//     bits. vga_plot is 0 from the following cycle; done is never asserted.
//   - Reset mid-operation: the engine returns to the reset state on the next edge, with no
//     further plots.
//   - Plot count: a full draw makes at most 256 plots. The first draw_link_done is seen
//     exactly 259 cycles after start is sampled.
// STRUCTURE
//   The shared package zelda_pkg holds SCREEN_W, SCREEN_H, COLOR_W, TRANSPARENT, the facing
//   encoding localparams and the state encoding.
//   Sub-module xy_scan_counter(W,H): a row/col counter with clear, enable and a last flag.
//   It is reused by the map and enemy drawers.
// TESTING
//   1. x=10,y=20,facing=1, all-opaque ROM (colour 3'b101) -> 256 plots covering x 10..25,
//      y 20..35, row-major; done rises on cycle 259 after start.
//   2. ROM with a transparent checkerboard -> exactly 128 plots, none with colour 3'b000.
//   3. x=152,y=112 -> only x 152..159 and y 112..119 are plotted (64 plots), with no
//      wrap to x<16.
//   4. start held high for 10 cycles after done -> done stays 1, no new plots; start low ->
//      done 0 next cycle; start high again -> second full draw.
//   5. start dropped at SCAN cycle 50 -> vga_plot 0 from the following cycle, done never
//      asserted, state IDLE.
//   6. reset asserted at SCAN cycle 100 -> all outputs 0 next cycle; x_pos/facing changed
//      mid-scan in an unreset run -> the plotted frame and position are unchanged.

Source files
------------

// File: rtl/zelda_pkg.sv
// Shared definitions for the game drawing engines: screen geometry, colour format,
// facing encoding and the draw-engine state encoding.
package zelda_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOR_W  = 3;
  localparam logic [COLOR_W-1:0] TRANSPARENT = 3'b000;

  localparam logic [1:0] FACE_UP    = 2'd0;
  localparam logic [1:0] FACE_DOWN  = 2'd1;
  localparam logic [1:0] FACE_LEFT  = 2'd2;
  localparam logic [1:0] FACE_RIGHT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} draw_state_t;
endpackage

// File: rtl/sprite_draw_engine_if.sv
// Sprite ROM read port and VGA adapter write port as seen by a drawing engine.
interface sprite_draw_engine_if import zelda_pkg::*; #(parameter int ADDR_W = 10);
  logic [ADDR_W-1:0]  rom_addr;
  logic [COLOR_W-1:0] rom_data;
  logic [7:0]         vga_x;
  logic [6:0]         vga_y;
  logic [COLOR_W-1:0] vga_colour;
  logic               vga_plot;

  modport master (output rom_addr, vga_x, vga_y, vga_colour, vga_plot, input rom_data);
  modport slave  (input rom_addr, vga_x, vga_y, vga_colour, vga_plot, output rom_data);
endinterface

// File: rtl/xy_scan_counter.sv
// Row-major W x H scan counter with clear, enable and a last-position flag.
module xy_scan_counter #(
  parameter int W = 16,
  parameter int H = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  output logic [$clog2(W)-1:0] col,
  output logic [$clog2(H)-1:0] row,
  output logic                 last
);
  localparam logic [$clog2(W)-1:0] COL_MAX = $clog2(W)'(W - 1);
  localparam logic [$clog2(H)-1:0] ROW_MAX = $clog2(H)'(H - 1);

  assign last = (col == COL_MAX) && (row == ROW_MAX);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (enable) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_draw_engine.sv
// DRAW_LINK phase: scans one sprite frame out of the ROM and plots its opaque,
// on-screen pixels at the position latched when start is first seen.
module sprite_draw_engine import zelda_pkg::*; #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_pos,
  input  logic [6:0] y_pos,
  input  logic [1:0] facing,
  output logic       done,
  sprite_draw_engine_if.master vga
);
  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  draw_state_t state, next;
  logic [7:0]       x_l;
  logic [6:0]       y_l;
  logic [1:0]       facing_l;
  logic [COL_W-1:0] col, s1_col;
  logic [ROW_W-1:0] row, s1_row;
  logic             last, flush_cnt, s1_valid;
  logic             latch, cnt_clear, cnt_en, abort;
  logic [8:0]       x_sum;
  logic [7:0]       y_sum;
  logic             on_screen;

  xy_scan_counter #(.W(SPRITE_W), .H(SPRITE_H)) u_scan (
    .clock(clock), .reset(reset), .clear(cnt_clear), .enable(cnt_en),
    .col(col), .row(row), .last(last)
  );

  assign vga.rom_addr = {facing_l, row, col};

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next      = state;
    latch     = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        next      = S_SCAN;
        latch     = 1'b1;
        cnt_clear = 1'b1;
      end
      S_SCAN: if (!start) begin
        next  = S_IDLE;
        abort = 1'b1;
      end else begin
        cnt_en = 1'b1;
        if (last) next = S_FLUSH;
      end
      S_FLUSH: if (!start) begin
        next  = S_IDLE;
        abort = 1'b1;
      end else if (flush_cnt) begin
        next = S_DONE;
      end
      S_DONE: if (!start) next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  // Sums are one bit wider than the screen coordinates so clipping never wraps.
  assign x_sum     = {1'b0, x_l} + 9'(s1_col);
  assign y_sum     = {1'b0, y_l} + 8'(s1_row);
  assign on_screen = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));

  always_ff @(posedge clock) begin
    if (reset) begin
      x_l            <= '0;
      y_l            <= '0;
      facing_l       <= '0;
      flush_cnt      <= 1'b0;
      s1_valid       <= 1'b0;
      s1_row         <= '0;
      s1_col         <= '0;
      vga.vga_x      <= '0;
      vga.vga_y      <= '0;
      vga.vga_colour <= '0;
      vga.vga_plot   <= 1'b0;
      done           <= 1'b0;
    end else begin
      if (latch) begin
        x_l      <= x_pos;
        y_l      <= y_pos;
        facing_l <= facing;
      end
      flush_cnt    <= (state == S_FLUSH);
      s1_valid     <= cnt_en;
      s1_row       <= row;
      s1_col       <= col;
      vga.vga_plot <= s1_valid && !abort && (vga.rom_data != TRANSPARENT) && on_screen;
      if (s1_valid) begin
        vga.vga_x      <= x_sum[7:0];
        vga.vga_y      <= y_sum[6:0];
        vga.vga_colour <= vga.rom_data;
      end
      done <= (next == S_DONE);
    end
  end
endmodule
